slave_port_v3: RTL and testbench
================================

// Module: slave_port_v3
// PURPOSE
//  Bit-serial system-bus slave with an address-decoded local memory. Receives serial write/read frames
//  from a master port, commits writes to a MEM_DEPTH-word array, streams read data back bit-serially.
//  Generalises slave_port_v2: parametrised depth/base address, range check with error pulse, clean abort.
//  Sits between the bus interconnect and a local memory/peripheral.
// PARAMETERS
//  ADDR_WIDTH  16      serial address bits per frame (MSB first)
//  DATA_WIDTH  8       serial data bits per word (MSB first)
//  MEM_DEPTH   64      words in local memory; power of two, <= 2**ADDR_WIDTH
//  BASE_ADDR   'h0000  first bus address decoded by this slave; aligned to MEM_DEPTH
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  rstn          in   1  synchronous active-low reset
//  mode          in   1  frame type, 1=write 0=read; sampled in IDLE when master_valid=1
//  wr_bus        in   1  serial address/data from master
//  master_valid  in   1  master driving a frame; low during ADDR/DATA aborts the frame
//  master_ready  in   1  master accepts current rd_bus bit this cycle
//  rd_bus        out  1  serial read data = shift_reg MSB
//  slave_ready   out  1  high in ADDR and DATA states
//  slave_valid   out  1  high in SEND state
//  slave_err     out  1  one-cycle pulse: out-of-range access (or parity fail, see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, addr/data/shift regs=0, rd_bus=0, slave_err=0; memory NOT cleared.
//  States: IDLE, ADDR, DATA, WRITE, READ, SEND.
//  IDLE: master_valid=1 -> latch mode, ADDR next cycle. Otherwise stay.
//  ADDR: each cycle master_valid=1 shifts wr_bus into addr reg, counter++; master_valid=0 -> IDLE, nothing
//   committed. After bit ADDR_WIDTH-1: mode=1 -> DATA (counter=0), mode=0 -> READ.
//  DATA: same sampling/abort rule; after bit DATA_WIDTH-1 -> WRITE.
//  WRITE (1 cycle): in range -> mem[addr-BASE_ADDR] <= data; else no write, slave_err=1. -> IDLE.
//  READ (1 cycle): shift_reg <= mem word (in range) or all-zeros (out of range, slave_err=1); counter=0. -> SEND.
//  SEND: slave_valid=1, rd_bus=shift_reg MSB; master_ready=1 -> shift left, counter++; master_ready=0
//   holds bit. After DATA_WIDTH accepted bits -> IDLE. master_valid ignored in SEND.
//  In range: BASE_ADDR <= addr < BASE_ADDR+MEM_DEPTH, full ADDR_WIDTH compare, no aliasing.
//  Latency: write committed on clock edge ending WRITE, i.e. 1 cycle after last data bit;
//   first read bit valid 2 cycles after last address bit (READ, then SEND).
//  Counter width $clog2(max(ADDR_WIDTH,DATA_WIDTH)+2); no wrap within a frame.
//  Back-to-back: new frame may start in the IDLE cycle following WRITE/SEND exit.
//  Reset mid-frame: frame dropped, outputs to reset values the next cycle, memory retains contents.
// CONFIGURATION
//  SLAVE_PORT_PARITY_EN defined: write frames carry one extra bit after data = even parity (^data);
//   mismatch -> write dropped, slave_err pulse in WRITE. Read frames send DATA_WIDTH+1 bits,
//   last bit = ^word. Not defined: no parity bit either direction, frame lengths as above.
// STRUCTURE
//  slave_port_pkg: state enum typedef, counter-width and frame-length localparam functions.
//  Sub-module slave_port_mem: MEM_DEPTH x DATA_WIDTH array, sync write, sync read (feeds READ state).
// TESTING (ADDR_WIDTH=16, DATA_WIDTH=8, MEM_DEPTH=64, BASE_ADDR='h0000)
//  1. Write 0x0005<-0xA5, then read 0x0005, master_ready=1 -> rd_bus 1,0,1,0,0,1,0,1; slave_valid 8 cycles; err 0.
//  2. Read 0x0005, master_ready alternating 1/0 -> each bit held through ready=0; SEND lasts 15 cycles, value 0xA5.
//  3. Write 0x0040<-0xFF -> slave_err pulse in WRITE, mem unchanged; read 0x0040 -> 0x00 streamed, err pulse.
//  4. Drop master_valid after 10 address bits -> IDLE next cycle, no write; following write 0x0001<-0x3C reads back 0x3C.
//  5. rstn=0 one cycle mid-SEND -> slave_valid/rd_bus 0 next cycle, IDLE; re-read returns original data.
//  6. PARITY_EN: write 0x0003<-0x01 with parity bit 0 -> dropped, err pulse; parity 1 -> stored, read sends 0x01 then 1.

Source files
------------

// File: rtl/slave_port_pkg.sv
// Shared definitions for the bit-serial slave port: FSM encoding and frame sizing.
// Frame lengths depend on SLAVE_PORT_PARITY_EN (adds one parity bit per data word).
package slave_port_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ADDR  = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_READ  = 3'd4;
    localparam state_t ST_SEND  = 3'd5;

    function automatic int cnt_width(input int aw, input int dw);
        int m;
        m = (aw > dw) ? aw : dw;
        return $clog2(m + 2);
    endfunction

    // Bits per serial data word on the wire, in both directions.
    function automatic int data_bits(input int dw);
`ifdef SLAVE_PORT_PARITY_EN
        return dw + 1;
`else
        return dw;
`endif
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/slave_port_mem.sv
// Local word memory: synchronous write, registered read. Contents survive reset.
module slave_port_mem
    import slave_port_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/slave_port_v3.sv
// Bit-serial bus slave: decodes write/read frames into a local memory, streams reads back.
// Optional parity on data words when SLAVE_PORT_PARITY_EN is defined.
module slave_port_v3
    import slave_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 64,
    parameter int BASE_ADDR  = 'h0000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       mode,
    input  logic       wr_bus,
    input  logic       master_valid,
    input  logic       master_ready,
    output logic       rd_bus,
    output logic       slave_ready,
    output logic       slave_valid,
    output logic       slave_err,
    output logic [2:0] dbg_state
);

    localparam int CNT_W = cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int FRM_W = data_bits(DATA_WIDTH);
    localparam int IDX_W = idx_width(MEM_DEPTH);

    localparam logic [ADDR_WIDTH:0] LO_ADDR   = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] HI_ADDR   = (ADDR_WIDTH+1)'(BASE_ADDR + MEM_DEPTH);
    localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0]    FRM_LAST  = CNT_W'(FRM_W - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [FRM_W-1:0]      r_shift;

    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  w_in_range;
    logic                  w_par_ok;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [FRM_W-1:0]      w_load;

    assign w_addr_next = {r_addr[ADDR_WIDTH-2:0], wr_bus};
    // BASE_ADDR is aligned to MEM_DEPTH, so the word index is just the low address bits.
    assign w_in_range  = ({1'b0, r_addr} >= LO_ADDR) && ({1'b0, r_addr} < HI_ADDR);

`ifdef SLAVE_PORT_PARITY_EN
    localparam logic [CNT_W-1:0] DW_CNT = CNT_W'(DATA_WIDTH);
    logic r_par;
    assign w_par_ok = (r_par == ^r_data);
    assign w_load   = w_in_range ? {w_rdata, ^w_rdata} : '0;
`else
    assign w_par_ok = 1'b1;
    assign w_load   = w_in_range ? w_rdata : '0;
`endif

    assign w_wr_en = (r_state == ST_WRITE) && w_in_range && w_par_ok;
    // Launch the memory read alongside the last address bit so the word is ready in READ.
    assign w_rd_en = (r_state == ST_ADDR) && master_valid && (r_cnt == ADDR_LAST) && !r_mode;

    slave_port_mem #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_addr[IDX_W-1:0]),
        .i_wdata (r_data),
        .i_re    (w_rd_en),
        .i_raddr (w_addr_next[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_shift <= '0;
`ifdef SLAVE_PORT_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (master_valid) begin
                        r_mode  <= mode;
                        r_cnt   <= '0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!master_valid) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_addr <= w_addr_next;
                        if (r_cnt == ADDR_LAST) begin
                            r_cnt   <= '0;
                            r_state <= r_mode ? ST_DATA : ST_READ;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (!master_valid) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
`ifdef SLAVE_PORT_PARITY_EN
                        if (r_cnt < DW_CNT)
                            r_data <= {r_data[DATA_WIDTH-2:0], wr_bus};
                        else
                            r_par <= wr_bus;
`else
                        r_data <= {r_data[DATA_WIDTH-2:0], wr_bus};
`endif
                        if (r_cnt == FRM_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_WRITE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                ST_READ: begin
                    r_shift <= w_load;
                    r_cnt   <= '0;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (master_ready) begin
                        r_shift <= {r_shift[FRM_W-2:0], 1'b0};
                        if (r_cnt == FRM_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_bus      = r_shift[FRM_W-1];
    assign slave_ready = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign slave_valid = (r_state == ST_SEND);
    assign slave_err   = ((r_state == ST_WRITE) && !(w_in_range && w_par_ok)) ||
                         ((r_state == ST_READ) && !w_in_range);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_slave_port_v3.sv
// Bench for slave_port_v3: literal vector table, hand-written corner sequences, random traffic vs a memory model.
module tb_slave_port_v3;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int BASE  = 'h0000;
`ifdef SLAVE_PORT_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic mode = 1'b0;
    logic wr_bus = 1'b0;
    logic master_valid = 1'b0;
    logic master_ready = 1'b0;
    logic rd_bus, slave_ready, slave_valid, slave_err;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [NB-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    slave_port_v3 #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .rd_bus       (rd_bus),
        .slave_ready  (slave_ready),
        .slave_valid  (slave_valid),
        .slave_err    (slave_err),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // reference model
    function automatic bit ref_in_range(input int a);
        return (a >= BASE) && (a < BASE + DEPTH);
    endfunction

    function automatic logic [NB-1:0] ref_stream(input logic [DW-1:0] w);
`ifdef SLAVE_PORT_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // driver tasks: inputs change at negedge, outputs sampled at negedge
    task automatic send_header(input bit m, input logic [AW-1:0] a, input int nbits, output bit rdy_ok);
        rdy_ok = 1'b1;
        @(negedge clk);
        master_valid = 1'b1;
        mode = m;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            rdy_ok &= slave_ready;
            wr_bus = a[AW-1-i];
        end
    endtask

    task automatic write_frame(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit par_bit, output bit err);
        bit ok;
        bit exp_err;
        send_header(1'b1, a, AW, ok);
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            ok &= slave_ready;
            wr_bus = d[DW-1-i];
        end
`ifdef SLAVE_PORT_PARITY_EN
        @(negedge clk);
        ok &= slave_ready;
        wr_bus = par_bit;
        exp_err = !ref_in_range(int'(a)) || (par_bit != ^d);
`else
        exp_err = !ref_in_range(int'(a)) || (par_bit && 1'b0);
`endif
        @(negedge clk);
        err = slave_err;
        check("wr_ready_during_frame", 32'(ok), 32'd1);
        check("wr_state_not_ready", 32'(slave_ready), 32'd0);
        check("wr_err", 32'(err), 32'(exp_err));
        master_valid = 1'b0;
        wr_bus = 1'b0;
        if (!exp_err)
            ref_mem[int'(a) - BASE] = d;
    endtask

    task automatic read_frame(input logic [AW-1:0] a, input bit alt_ready,
                              output logic [NB-1:0] got, output bit err, output int cycles);
        bit ok;
        int nacc;
        logic [NB-1:0] exp;
        exp_q.push_back(ref_in_range(int'(a)) ? ref_stream(ref_mem[int'(a) - BASE]) : '0);
        send_header(1'b0, a, AW, ok);
        @(negedge clk);
        err = slave_err;
        check("rd_ready_during_addr", 32'(ok), 32'd1);
        check("rd_not_valid_in_read", 32'(slave_valid), 32'd0);
        check("rd_err", 32'(err), 32'(!ref_in_range(int'(a))));
        master_valid = 1'b0;
        wr_bus = 1'b0;
        got = '0;
        nacc = 0;
        cycles = 0;
        for (int t = 0; t < 4 * NB + 4; t++) begin
            @(negedge clk);
            if (!slave_valid) break;
            cycles++;
            master_ready = alt_ready ? ((cycles % 2) == 1) : 1'b1;
            if (master_ready) begin
                got = {got[NB-2:0], rd_bus};
                nacc++;
            end
        end
        master_ready = 1'b0;
        check("rd_bits_accepted", 32'(nacc), 32'(NB));
        exp = exp_q.pop_front();
        check("rd_data", 32'(got), 32'(exp));
    endtask

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_val;
        bit            exp_err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [NB-1:0] got;
        logic [NB-1:0] lit;
        bit err;
        bit ok;
        int cyc;

        vecs[0]  = '{1'b1, 16'h0000, 8'hC3, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 16'h0005, 8'hA5, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 16'h0005, 8'h00, 8'hA5, 1'b0};
        vecs[3]  = '{1'b1, 16'h0040, 8'hFF, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 16'h0040, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 8'h00, 8'hC3, 1'b0};
        vecs[6]  = '{1'b1, 16'h003F, 8'h5A, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 16'h003F, 8'h00, 8'h5A, 1'b0};
        vecs[8]  = '{1'b1, 16'hFFFF, 8'h11, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 16'h0005, 8'h00, 8'hA5, 1'b0};

        // reset state
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(slave_ready), 32'd0);
        check("reset_valid", 32'(slave_valid), 32'd0);
        check("reset_err", 32'(slave_err), 32'd0);
        check("reset_rd_bus", 32'(rd_bus), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rstn = 1'b1;

        // vector table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                write_frame(vecs[i].addr, vecs[i].data, ^vecs[i].data, err);
                check($sformatf("vec%0d_wr_err", i), 32'(err), 32'(vecs[i].exp_err));
            end else begin
                read_frame(vecs[i].addr, 1'b0, got, err, cyc);
                lit = ref_stream(vecs[i].exp_val);
                check($sformatf("vec%0d_rd_data", i), 32'(got), 32'(lit));
                check($sformatf("vec%0d_rd_err", i), 32'(err), 32'(vecs[i].exp_err));
                check($sformatf("vec%0d_rd_cycles", i), 32'(cyc), 32'(NB));
            end
        end

        // read with master_ready alternating: each bit held across the stall
        read_frame(16'h0005, 1'b1, got, err, cyc);
        lit = ref_stream(8'hA5);
        check("alt_ready_data", 32'(got), 32'(lit));
        check("alt_ready_cycles", 32'(cyc), 32'(2 * NB - 1));

        // abort after 10 address bits
        send_header(1'b1, 16'h0002, 10, ok);
        @(negedge clk);
        master_valid = 1'b0;
        @(negedge clk);
        check("abort_addr_idle", 32'(dbg_state), 32'd0);
        check("abort_addr_not_ready", 32'(slave_ready), 32'd0);
        write_frame(16'h0001, 8'h3C, 1'b0 ^ (^8'h3C), err);
        read_frame(16'h0001, 1'b0, got, err, cyc);
        lit = ref_stream(8'h3C);
        check("after_abort_data", 32'(got), 32'(lit));

        // abort in the data phase must not commit
        write_frame(16'h0002, 8'h77, ^8'h77, err);
        send_header(1'b1, 16'h0002, AW, ok);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_bus = 1'b1;
        end
        @(negedge clk);
        master_valid = 1'b0;
        @(negedge clk);
        check("abort_data_idle", 32'(dbg_state), 32'd0);
        read_frame(16'h0002, 1'b0, got, err, cyc);
        lit = ref_stream(8'h77);
        check("abort_data_mem_kept", 32'(got), 32'(lit));

        // reset for one cycle in the middle of SEND
        send_header(1'b0, 16'h0005, AW, ok);
        @(negedge clk);
        master_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            master_ready = 1'b1;
        end
        @(negedge clk);
        check("mid_send_valid", 32'(slave_valid), 32'd1);
        master_ready = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("rst_send_valid", 32'(slave_valid), 32'd0);
        check("rst_send_rd_bus", 32'(rd_bus), 32'd0);
        check("rst_send_state", 32'(dbg_state), 32'd0);
        read_frame(16'h0005, 1'b0, got, err, cyc);
        lit = ref_stream(8'hA5);
        check("rst_send_reread", 32'(got), 32'(lit));

`ifdef SLAVE_PORT_PARITY_EN
        write_frame(16'h0003, 8'h01, 1'b0, err);
        check("par_bad_err", 32'(err), 32'd1);
        write_frame(16'h0003, 8'h01, 1'b1, err);
        check("par_good_err", 32'(err), 32'd0);
        read_frame(16'h0003, 1'b0, got, err, cyc);
        lit = 9'b0_0000_0011;
        check("par_read_stream", 32'(got), 32'(lit));
`endif

        // fill every word so the model is fully defined, then random traffic
        for (int a = 0; a < DEPTH; a++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            write_frame(AW'(BASE + a), d, ^d, err);
        end
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            bit p;
            a = AW'($urandom_range(BASE, BASE + DEPTH + 15));
            if ($urandom_range(0, 4) == 0)
                a = AW'($urandom_range(0, 65535));
            d = DW'($urandom);
            p = ^d;
            if ($urandom_range(0, 4) == 0)
                p = ~p;
            if ($urandom_range(0, 1) == 1)
                write_frame(a, d, p, err);
            else
                read_frame(a, 1'($urandom_range(0, 1)), got, err, cyc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
